// File: rtl/fir_scan_rx.sv
// fir_scan_rx: deserializes the FIR weight/sample scan streams into tap-tagged words
// and buffers them in a small fall-through FIFO with sticky overflow/sign-extension flags.
module fir_scan_rx #(
  parameter int TAPS  = 256,
  parameter int M     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   scan_en_i,
  input  logic                   scan_in_x_i,
  input  logic                   scan_in_w_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [15:0]            out_x_o,
  output logic [25:0]            out_w_o,
  output logic [M-1:0]           out_tap_o,
  output logic                   frame_done_o,
  output logic                   overflow_o,
  output logic                   sext_err_o,
  output logic [$clog2(DEPTH):0] fifo_level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [M-1:0] TAP_TOP = M'(TAPS - 1);

  logic          scan_en_q;
  logic [4:0]    bcnt_q, bcnt_d;
  logic [25:0]   sr_x_q, sr_w_q, word_x, word_w;
  logic [M-1:0]  tap_cnt_q, tap_cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
  logic [AW:0]   level_q, level_d;
  logic [15:0]   head_x_q;
  logic [25:0]   head_w_q;
  logic [M-1:0]  head_tap_q;
  logic          frame_done_q, overflow_q, sext_err_q;
  logic          push, pop, full, wr, sext_bad;
  logic [15:0]   mem_x [DEPTH];
  logic [25:0]   mem_w [DEPTH];
  logic [M-1:0]  mem_tap [DEPTH];

  always_comb begin
    word_x    = {scan_in_x_i, sr_x_q[25:1]};
    word_w    = {scan_in_w_i, sr_w_q[25:1]};
    push      = scan_en_q && (bcnt_q == 5'd25);
    pop       = out_valid_o && out_ready_i;
    full      = level_q == (AW+1)'(DEPTH);
    wr        = push && (!full || pop);
    sext_bad  = word_x[25:15] != {11{word_x[25]}};
    rd_nxt    = rd_ptr_q + AW'(1);
    level_d   = level_q + (AW+1)'(wr) - (AW+1)'(pop);
    bcnt_d    = push ? 5'd0 : bcnt_q + 5'd1;
    tap_cnt_d = tap_cnt_q - M'(1);
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_x[wr_ptr_q]   <= word_x[15:0];
      mem_w[wr_ptr_q]   <= word_w;
      mem_tap[wr_ptr_q] <= tap_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_en_q    <= 1'b0;
      bcnt_q       <= '0;
      sr_x_q       <= '0;
      sr_w_q       <= '0;
      tap_cnt_q    <= TAP_TOP;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      head_x_q     <= '0;
      head_w_q     <= '0;
      head_tap_q   <= TAP_TOP;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      sext_err_q   <= 1'b0;
    end else begin
      scan_en_q <= scan_en_i;
      if (clr_i) begin
        bcnt_q       <= '0;
        sr_x_q       <= '0;
        sr_w_q       <= '0;
        tap_cnt_q    <= TAP_TOP;
        wr_ptr_q     <= '0;
        rd_ptr_q     <= '0;
        level_q      <= '0;
        head_x_q     <= '0;
        head_w_q     <= '0;
        head_tap_q   <= TAP_TOP;
        frame_done_q <= 1'b0;
        overflow_q   <= 1'b0;
        sext_err_q   <= 1'b0;
      end else begin
        if (scan_en_q) begin
          sr_x_q <= word_x;
          sr_w_q <= word_w;
          bcnt_q <= bcnt_d;
        end
        if (push) tap_cnt_q <= tap_cnt_d;
        frame_done_q <= push && (tap_cnt_q == '0);
        if (push && full && !pop) overflow_q <= 1'b1;
        if (push && sext_bad) sext_err_q <= 1'b1;
        if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) rd_ptr_q <= rd_nxt;
        level_q <= level_d;
        // Head register mirrors the FIFO entry at rd_ptr; a push into an emptying FIFO bypasses storage.
        if (pop && level_q > (AW+1)'(1)) begin
          head_x_q   <= mem_x[rd_nxt];
          head_w_q   <= mem_w[rd_nxt];
          head_tap_q <= mem_tap[rd_nxt];
        end else if (wr && (level_q == '0 || pop)) begin
          head_x_q   <= word_x[15:0];
          head_w_q   <= word_w;
          head_tap_q <= tap_cnt_q;
        end
      end
    end
  end

  assign out_valid_o  = level_q != '0;
  assign out_x_o      = head_x_q;
  assign out_w_o      = head_w_q;
  assign out_tap_o    = head_tap_q;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;
  assign sext_err_o   = sext_err_q;
  assign fifo_level_o = level_q;
endmodule

// File: tb/tb_fir_scan_rx.sv
// tb_fir_scan_rx: directed bench driving an LSB-first FIR scan model into a 256-tap
// and a 4-tap receiver sharing the same inputs.
module tb_fir_scan_rx;
  logic clk = 0, rst_n = 0, clr = 0, scan_en = 0, x_line = 0, w_line = 0, out_ready = 0;
  logic        valid, fd, ovf, sext;
  logic [15:0] ox;
  logic [25:0] ow;
  logic [7:0]  otap;
  logic [2:0]  lvl;
  logic        valid4, fd4, ovf4, sext4;
  logic [15:0] ox4;
  logic [25:0] ow4;
  logic [1:0]  otap4;
  logic [2:0]  lvl4;
  logic [25:0] wx [8];
  logic [25:0] ww [8];
  int n_checks = 0, n_fail = 0;
  bit mon_en = 0;
  int q_tap[$], q_w[$], q_x[$];
  int fd_cnt = 0, fd_idx = -1;

  always #5 clk = ~clk;

  fir_scan_rx #(.TAPS(256), .M(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .scan_en_i(scan_en),
    .scan_in_x_i(x_line), .scan_in_w_i(w_line), .out_valid_o(valid),
    .out_ready_i(out_ready), .out_x_o(ox), .out_w_o(ow), .out_tap_o(otap),
    .frame_done_o(fd), .overflow_o(ovf), .sext_err_o(sext), .fifo_level_o(lvl));

  fir_scan_rx #(.TAPS(4), .M(2), .DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr_i(clr), .scan_en_i(scan_en),
    .scan_in_x_i(x_line), .scan_in_w_i(w_line), .out_valid_o(valid4),
    .out_ready_i(out_ready), .out_x_o(ox4), .out_w_o(ow4), .out_tap_o(otap4),
    .frame_done_o(fd4), .overflow_o(ovf4), .sext_err_o(sext4), .fifo_level_o(lvl4));

  always @(negedge clk) begin
    if (mon_en && valid4 && out_ready) begin
      q_tap.push_back(int'(otap4));
      q_w.push_back(int'(ow4));
      q_x.push_back(int'(ox4));
    end
    if (mon_en && fd4) begin
      fd_cnt++;
      fd_idx = q_tap.size();
    end
  end

  // FIR model: word bit k is on the line after edge k of the word; scan_en drops with the last bit.
  task automatic scan(input int n, input int pause_at, input int abort_at, input bit ready_last);
    @(negedge clk);
    scan_en = 1;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 26; k++) begin
        @(posedge clk);
        @(negedge clk);
        x_line = wx[j][k];
        w_line = ww[j][k];
        if (j == 0 && k == abort_at) begin
          rst_n = 0;
          scan_en = 0;
          return;
        end
        if (j == n - 1 && k == 25) begin
          scan_en = 0;
          if (ready_last) out_ready = 1;
        end
        if (j == 0 && k == pause_at) begin
          scan_en = 0;
          repeat (7) @(negedge clk);
          scan_en = 1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (ready_last) out_ready = 0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", valid); end
    n_checks++; if (lvl !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", lvl); end
    n_checks++; if ({fd, ovf, sext} !== 3'b000) begin n_fail++; $display("FAIL reset_flags got %b exp 000", {fd, ovf, sext}); end
    n_checks++; if (ox !== 16'h0 || ow !== 26'h0) begin n_fail++; $display("FAIL reset_data got %h/%h exp 0/0", ox, ow); end
    n_checks++; if (otap !== 8'd255 || otap4 !== 2'd3) begin n_fail++; $display("FAIL reset_tap got %0d/%0d exp 255/3", otap, otap4); end
  endtask

  task automatic test_single();
    do_clr();
    out_ready = 1;
    wx[0] = 26'h3FF8001;
    ww[0] = 26'h0123456;
    scan(1, -1, -1, 0);
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b exp 1", valid); end
    n_checks++; if (ox !== 16'h8001) begin n_fail++; $display("FAIL single_x got %h exp 8001", ox); end
    n_checks++; if (ow !== 26'h0123456) begin n_fail++; $display("FAIL single_w got %h exp 0123456", ow); end
    n_checks++; if (otap !== 8'd255) begin n_fail++; $display("FAIL single_tap got %0d exp 255", otap); end
    n_checks++; if (sext !== 1'b0 || fd !== 1'b0) begin n_fail++; $display("FAIL single_flags got %b%b exp 00", sext, fd); end
    @(negedge clk);
    n_checks++; if (valid !== 1'b0 || lvl !== 3'd0) begin n_fail++; $display("FAIL single_popped got %b/%0d exp 0/0", valid, lvl); end
    out_ready = 0;
  endtask

  task automatic test_sext();
    do_clr();
    wx[0] = 26'h0008000;
    ww[0] = 26'h3FFFFFF;
    scan(1, -1, -1, 0);
    n_checks++; if (sext !== 1'b1) begin n_fail++; $display("FAIL sext_set got %b exp 1", sext); end
    n_checks++; if (ox !== 16'h8000) begin n_fail++; $display("FAIL sext_x got %h exp 8000", ox); end
    repeat (5) @(negedge clk);
    n_checks++; if (sext !== 1'b1) begin n_fail++; $display("FAIL sext_sticky got %b exp 1", sext); end
    do_clr();
    n_checks++; if (sext !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL sext_clr got %b/%b exp 0/0", sext, valid); end
  endtask

  task automatic test_full_frame();
    do_clr();
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      ww[i] = 26'(i + 1);
      wx[i] = 26'(16'h0A0 + i);
    end
    q_tap.delete(); q_w.delete(); q_x.delete();
    fd_cnt = 0; fd_idx = -1;
    mon_en = 1;
    scan(4, -1, -1, 0);
    repeat (2) @(negedge clk);
    mon_en = 0;
    out_ready = 0;
    n_checks++; if (q_tap.size() != 4) begin n_fail++; $display("FAIL frame_count got %0d exp 4", q_tap.size()); end
    for (int i = 0; i < 4 && i < q_tap.size(); i++) begin
      n_checks++;
      if (q_tap[i] != 3 - i || q_w[i] != i + 1 || q_x[i] != 16'h0A0 + i) begin
        n_fail++;
        $display("FAIL frame_word%0d got tap %0d w %0d x %h exp tap %0d w %0d x %h", i, q_tap[i], q_w[i], q_x[i], 3 - i, i + 1, 16'h0A0 + i);
      end
    end
    n_checks++; if (fd_cnt != 1 || fd_idx != 4) begin n_fail++; $display("FAIL frame_done got %0d pulses at push %0d exp 1 at 4", fd_cnt, fd_idx); end
  endtask

  task automatic test_pause();
    do_clr();
    wx[0] = 26'h0001234;
    ww[0] = 26'h2ABCDEF;
    scan(1, 10, -1, 0);
    n_checks++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL pause_level got %0d exp 1", lvl); end
    n_checks++; if (ox !== 16'h1234 || ow !== 26'h2ABCDEF || otap !== 8'd255) begin n_fail++; $display("FAIL pause_word got %h/%h/%0d exp 1234/2abcdef/255", ox, ow, otap); end
    repeat (30) @(negedge clk);
    n_checks++; if (lvl !== 3'd1) begin n_fail++; $display("FAIL pause_extra got %0d exp 1", lvl); end
  endtask

  task automatic test_overflow(input bit ready_last);
    int base;
    do_clr();
    base = ready_last ? 1 : 0;
    for (int i = 0; i < 5; i++) begin
      wx[i] = 26'(i);
      ww[i] = 26'(12'h100 + i);
    end
    scan(5, -1, -1, ready_last);
    n_checks++; if (lvl !== 3'd4) begin n_fail++; $display("FAIL ovf%0d_level got %0d exp 4", ready_last, lvl); end
    n_checks++; if (ovf !== !ready_last) begin n_fail++; $display("FAIL ovf%0d_flag got %b exp %b", ready_last, ovf, !ready_last); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (valid !== 1'b1 || otap !== 8'(255 - base - i) || ow !== 26'(12'h100 + base + i)) begin
        n_fail++;
        $display("FAIL ovf%0d_drain%0d got v %b tap %0d w %h exp v 1 tap %0d w %h", ready_last, i, valid, otap, ow, 255 - base - i, 12'h100 + base + i);
      end
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
    end
    n_checks++; if (valid !== 1'b0 || lvl !== 3'd0) begin n_fail++; $display("FAIL ovf%0d_empty got %b/%0d exp 0/0", ready_last, valid, lvl); end
  endtask

  task automatic test_reset_mid();
    do_clr();
    wx[0] = 26'h0000AAA;
    ww[0] = 26'h1555555;
    scan(1, -1, -1, 0);
    wx[0] = 26'h3FFC003;
    ww[0] = 26'h0F0F0F0;
    scan(1, -1, 12, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0 || lvl !== 3'd0) begin n_fail++; $display("FAIL rstmid_fifo got %b/%0d exp 0/0", valid, lvl); end
    n_checks++; if (ox !== 16'h0 || ow !== 26'h0 || otap !== 8'd255) begin n_fail++; $display("FAIL rstmid_out got %h/%h/%0d exp 0/0/255", ox, ow, otap); end
    scan(1, -1, -1, 0);
    n_checks++; if (lvl !== 3'd1 || otap !== 8'd255) begin n_fail++; $display("FAIL rstmid_fresh got level %0d tap %0d exp 1/255", lvl, otap); end
    n_checks++; if (ox !== 16'hC003 || ow !== 26'h0F0F0F0 || sext !== 1'b0) begin n_fail++; $display("FAIL rstmid_word got %h/%h/%b exp c003/0f0f0f0/0", ox, ow, sext); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sext();
    test_full_frame();
    test_pause();
    test_overflow(0);
    test_overflow(1);
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
